// File: rtl/iface_rsp_responder.sv
// -----------------------------------------------------------------------------
// iface_rsp_responder
//
// Target-side end of the parameterized request/response interface. Requests
// ({req_id, req_data}) are queued in a DEPTH-entry FIFO and served one at a
// time by a three-state controller (IDLE -> PROC -> RESP). Each response
// carries the original tag, the payload plus DW (truncated to DW bits) and an
// overflow flag for the carry out of that addition.
//
// Parameters
//   DW     payload width, 1..32
//   DEPTH  FIFO entries, power of two, >= 2
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_valid  request present
//   req_ready  responder can accept a request (FIFO not full)
//   req_data   request payload [DW]
//   req_id     request tag [4]
//   rsp_valid  response present (high only in RESP)
//   rsp_ready  initiator accepts the response
//   rsp_data   response payload [DW]
//   rsp_id     tag copied from the request [4]
//   rsp_err    payload addition overflowed
//   occupancy  FIFO entries in use [$clog2(DEPTH)+1]
//   err_count  saturating count of delivered responses with rsp_err=1 [8]
// -----------------------------------------------------------------------------
module iface_rsp_responder #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [DW-1:0]            req_data,
   input  logic [3:0]               req_id,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DW-1:0]            rsp_data,
   output logic [3:0]               rsp_id,
   output logic                     rsp_err,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [7:0]               err_count
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PROC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Payload plus DW with the carry kept as the top bit.
   function automatic logic [DW:0] add_width(input logic [DW-1:0] d);
      return {1'b0, d} + (DW+1)'(DW);
   endfunction

   // Counter increment that sticks at all-ones.
   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   logic [1:0]      state;
   logic [DW+3:0]   fifo_mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     occ;
   logic [DW-1:0]   head_data_p0;
   logic [3:0]      head_id_p0;
   logic            push;
   logic            pop;
   logic            rsp_hs;
   logic [DW:0]     sum_p1;

   // Ready depends only on registered occupancy, so a pop on a full cycle
   // cannot open the door for a push on that same edge.
   assign req_ready = (occ != (AW+1)'(DEPTH));
   assign push      = req_valid && req_ready;
   assign pop       = (state == S_IDLE) && (occ != '0);
   assign rsp_valid = (state == S_RESP);
   assign rsp_hs    = rsp_valid && rsp_ready;
   assign occupancy = occ;
   assign sum_p1    = add_width(head_data_p0);

   // ---- stage 0: FIFO write / pointer bookkeeping
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {req_id, req_data};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // ---- stage 1: head capture on the IDLE -> PROC edge
   always_ff @(posedge clk) begin
      if (pop) begin
         {head_id_p0, head_data_p0} <= fifo_mem[rd_ptr];
      end
   end

   // ---- stage 2: control FSM and registered response
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         rsp_data  <= '0;
         rsp_id    <= '0;
         rsp_err   <= 1'b0;
         err_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  state <= S_PROC;
               end
            end
            S_PROC: begin
               rsp_data <= sum_p1[DW-1:0];
               rsp_err  <= sum_p1[DW];
               rsp_id   <= head_id_p0;
               state    <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
         if (rsp_hs && rsp_err) begin
            err_count <= sat_inc(err_count);
         end
      end
   end

endmodule

// File: tb/tb_iface_rsp_responder.sv
// -----------------------------------------------------------------------------
// tb_iface_rsp_responder
//
// Directed bench for iface_rsp_responder. A DW=8 instance carries most
// scenarios; DW=1 and DW=32 instances cover the width extremes. Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_iface_rsp_responder;

   logic        clk = 1'b0;
   logic        rst_n;

   // DW=8 instance
   logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
   logic [7:0]  req_data, rsp_data, err_count;
   logic [3:0]  req_id, rsp_id;
   logic [2:0]  occupancy;

   // DW=1 instance
   logic        w1_req_valid, w1_req_ready, w1_rsp_valid, w1_rsp_ready, w1_rsp_err;
   logic [0:0]  w1_req_data, w1_rsp_data;
   logic [3:0]  w1_req_id, w1_rsp_id;
   logic [2:0]  w1_occupancy;
   logic [7:0]  w1_err_count;

   // DW=32 instance
   logic        w32_req_valid, w32_req_ready, w32_rsp_valid, w32_rsp_ready, w32_rsp_err;
   logic [31:0] w32_req_data, w32_rsp_data;
   logic [3:0]  w32_req_id, w32_rsp_id;
   logic [2:0]  w32_occupancy;
   logic [7:0]  w32_err_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   iface_rsp_responder #(.DW(8), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_id(req_id),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
      .rsp_err(rsp_err), .occupancy(occupancy), .err_count(err_count)
   );

   iface_rsp_responder #(.DW(1), .DEPTH(4)) dut_w1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(w1_req_valid), .req_ready(w1_req_ready), .req_data(w1_req_data), .req_id(w1_req_id),
      .rsp_valid(w1_rsp_valid), .rsp_ready(w1_rsp_ready), .rsp_data(w1_rsp_data), .rsp_id(w1_rsp_id),
      .rsp_err(w1_rsp_err), .occupancy(w1_occupancy), .err_count(w1_err_count)
   );

   iface_rsp_responder #(.DW(32), .DEPTH(4)) dut_w32 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(w32_req_valid), .req_ready(w32_req_ready), .req_data(w32_req_data), .req_id(w32_req_id),
      .rsp_valid(w32_rsp_valid), .rsp_ready(w32_rsp_ready), .rsp_data(w32_rsp_data), .rsp_id(w32_rsp_id),
      .rsp_err(w32_rsp_err), .occupancy(w32_occupancy), .err_count(w32_err_count)
   );

   // Reference response for DW=8: payload + 8 wrapped to a byte.
   function automatic logic [7:0] ref_data8(input int d);
      return 8'((d + 8) % 256);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 1'b0; req_data = 8'hA5; req_id = 4'hC; rsp_ready = 1'b0;
      w1_req_valid = 1'b0; w1_req_data = 1'b0; w1_req_id = 4'h0; w1_rsp_ready = 1'b1;
      w32_req_valid = 1'b0; w32_req_data = '0; w32_req_id = 4'h0; w32_rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
      checks++; if ({rsp_data, rsp_id, rsp_err} !== 13'd0) begin errors++; $display("FAIL reset_rsp_fields: got %h want 0", {rsp_data, rsp_id, rsp_err}); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_data = 8'h10; req_id = 4'd3;
      @(negedge clk);                       // E0: accepted
      req_valid = 1'b0; req_data = 8'hFF; req_id = 4'hF;
      checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL single_occ_after_accept: got %0d want 1", occupancy); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_e0: got %b want 0", rsp_valid); end
      @(negedge clk);                       // E1: popped
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_e1: got %b want 0", rsp_valid); end
      @(negedge clk);                       // E2: response registered
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid_e2: got %b want 1", rsp_valid); end
      checks++; if (rsp_data !== 8'h18) begin errors++; $display("FAIL single_data: got %h want 18", rsp_data); end
      checks++; if (rsp_id !== 4'd3) begin errors++; $display("FAIL single_id: got %0d want 3", rsp_id); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", rsp_err); end
      @(negedge clk);                       // E3: handshake
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after_hs: got %b want 0", rsp_valid); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL single_occ_end: got %0d want 0", occupancy); end
   endtask

   task automatic test_overflow();
      logic [7:0] in_v  [3] = '{8'd247, 8'd248, 8'd255};
      logic [7:0] out_v [3] = '{8'd255, 8'd0, 8'd7};
      logic       err_v [3] = '{1'b0, 1'b1, 1'b1};
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1; req_data = in_v[i]; req_id = 4'(i + 1);
         @(negedge clk);
         req_valid = 1'b0;
         for (int k = 0; k < 8 && !rsp_valid; k++) @(negedge clk);
         checks++;
         if (!rsp_valid) begin
            errors++; $display("FAIL overflow_timeout[%0d]: rsp_valid %b want 1", i, rsp_valid);
         end else if ({rsp_data, rsp_err} !== {out_v[i], err_v[i]}) begin
            errors++; $display("FAIL overflow_rsp[%0d]: got data %0d err %b want data %0d err %b", i, rsp_data, rsp_err, out_v[i], err_v[i]);
         end
         @(negedge clk);
      end
      checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL overflow_err_count: got %0d want 2", err_count); end
   endtask

   task automatic test_fill_backpressure();
      int idx = 0;
      int exp = 0;
      logic acc;
      logic [7:0] held;
      rsp_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         req_valid = 1'b1; req_data = 8'(idx * 10); req_id = 4'(idx);
         acc = req_ready;
         @(negedge clk);
         if (acc) idx++;
      end
      checks++; if (idx !== 5) begin errors++; $display("FAIL fill_accepted: got %0d want 5", idx); end
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fill_occ: got %0d want 4", occupancy); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fill_req_ready: got %b want 0", req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 4'd0) begin errors++; $display("FAIL fill_head: got valid %b id %0d want 1 id 0", rsp_valid, rsp_id); end
      held = rsp_data;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (rsp_data !== 8'd8 || rsp_data !== held) begin errors++; $display("FAIL fill_stall_stable[%0d]: got %0d want 8", c, rsp_data); end
      end
      rsp_ready = 1'b1;
      for (int c = 0; c < 60 && exp < 6; c++) begin
         acc = req_valid && req_ready;
         if (rsp_valid) begin
            checks++; if (rsp_id !== 4'(exp)) begin errors++; $display("FAIL fill_order_id: got %0d want %0d", rsp_id, exp); end
            checks++; if (rsp_data !== ref_data8(exp * 10)) begin errors++; $display("FAIL fill_order_data: got %0d want %0d", rsp_data, ref_data8(exp * 10)); end
            exp++;
         end
         @(negedge clk);
         if (acc) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      checks++; if (exp !== 6) begin errors++; $display("FAIL fill_resp_count: got %0d want 6", exp); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL fill_occ_end: got %0d want 0", occupancy); end
   endtask

   task automatic test_push_pop();
      int exp;
      int sent = 0;
      int got = 0;
      logic acc;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1; req_data = 8'(i + 1); req_id = 4'(6 + i);
         @(negedge clk);
      end
      req_valid = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 4'd6 || occupancy !== 3'd2) begin errors++; $display("FAIL pp_setup: got valid %b id %0d occ %0d want 1 6 2", rsp_valid, rsp_id, occupancy); end
      rsp_ready = 1'b1;
      @(negedge clk);                       // handshake, back to IDLE with 2 queued
      checks++; if (rsp_valid !== 1'b0 || occupancy !== 3'd2) begin errors++; $display("FAIL pp_idle: got valid %b occ %0d want 0 2", rsp_valid, occupancy); end
      req_valid = 1'b1; req_data = 8'd4; req_id = 4'd9;
      @(negedge clk);                       // pop and push on the same edge
      req_valid = 1'b0;
      checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL pp_same_edge_occ: got %0d want 2", occupancy); end
      exp = 7;
      for (int c = 0; c < 30 && exp < 10; c++) begin
         if (rsp_valid) begin
            checks++; if (rsp_id !== 4'(exp) || rsp_data !== 8'(exp + 3)) begin errors++; $display("FAIL pp_drain: got id %0d data %0d want id %0d data %0d", rsp_id, rsp_data, exp, exp + 3); end
            exp++;
         end
         @(negedge clk);
      end
      checks++; if (exp !== 10) begin errors++; $display("FAIL pp_drain_count: got %0d want 10", exp); end
      // stream of 20 requests through the 4-entry FIFO
      for (int c = 0; c < 300 && got < 20; c++) begin
         if (sent < 20) begin
            req_valid = 1'b1; req_data = 8'(sent * 13); req_id = 4'(sent);
         end else begin
            req_valid = 1'b0;
         end
         acc = req_valid && req_ready;
         if (rsp_valid) begin
            checks++; if (rsp_id !== 4'(got) || rsp_data !== ref_data8(got * 13)) begin errors++; $display("FAIL wrap_stream[%0d]: got id %0d data %0d want id %0d data %0d", got, rsp_id, rsp_data, 4'(got), ref_data8(got * 13)); end
            got++;
         end
         @(negedge clk);
         if (acc) sent++;
      end
      req_valid = 1'b0;
      checks++; if (got !== 20 || sent !== 20) begin errors++; $display("FAIL wrap_counts: got %0d responses %0d sent want 20 20", got, sent); end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_data = 8'(200 + i * 20); req_id = 4'(10 + i);
         @(negedge clk);
      end
      req_valid = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || occupancy !== 3'd3) begin errors++; $display("FAIL mid_setup: got valid %b occ %0d want 1 3", rsp_valid, occupancy); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== 14'd0) begin errors++; $display("FAIL mid_outputs: got %h want 0", {rsp_valid, rsp_data, rsp_id, rsp_err}); end
      checks++; if (occupancy !== 3'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_fifo: got occ %0d ready %b want 0 1", occupancy, req_ready); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL mid_err_count: got %0d want 0", err_count); end
      rsp_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (rsp_valid) seen++;
         @(negedge clk);
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL mid_stale: got %0d responses want 0", seen); end
   endtask

   task automatic test_widths();
      logic [0:0]  w1_in  [2] = '{1'b0, 1'b1};
      logic [0:0]  w1_out [2] = '{1'b1, 1'b0};
      logic        w1_e   [2] = '{1'b0, 1'b1};
      logic [31:0] w32_in [2] = '{32'hFFFF_FFE0, 32'd5};
      logic [31:0] w32_out[2] = '{32'h0000_0000, 32'd37};
      logic        w32_e  [2] = '{1'b1, 1'b0};
      for (int i = 0; i < 2; i++) begin
         w1_req_valid = 1'b1; w1_req_data = w1_in[i]; w1_req_id = 4'(1 + i);
         w32_req_valid = 1'b1; w32_req_data = w32_in[i]; w32_req_id = 4'(4 + i);
         @(negedge clk);
         w1_req_valid = 1'b0; w32_req_valid = 1'b0;
         for (int k = 0; k < 8 && !w1_rsp_valid; k++) @(negedge clk);
         checks++;
         if (w1_rsp_valid !== 1'b1 || {w1_rsp_data, w1_rsp_err, w1_rsp_id} !== {w1_out[i], w1_e[i], 4'(1 + i)}) begin
            errors++; $display("FAIL dw1[%0d]: got v %b d %b e %b id %0d want v 1 d %b e %b id %0d", i, w1_rsp_valid, w1_rsp_data, w1_rsp_err, w1_rsp_id, w1_out[i], w1_e[i], 1 + i);
         end
         checks++;
         if (w32_rsp_valid !== 1'b1 || {w32_rsp_data, w32_rsp_err, w32_rsp_id} !== {w32_out[i], w32_e[i], 4'(4 + i)}) begin
            errors++; $display("FAIL dw32[%0d]: got v %b d %h e %b id %0d want v 1 d %h e %b id %0d", i, w32_rsp_valid, w32_rsp_data, w32_rsp_err, w32_rsp_id, w32_out[i], w32_e[i], 4 + i);
         end
         @(negedge clk);
      end
      checks++; if (w1_err_count !== 8'd1 || w32_err_count !== 8'd1) begin errors++; $display("FAIL width_err_counts: got %0d %0d want 1 1", w1_err_count, w32_err_count); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_fill_backpressure();
      test_push_pop();
      test_reset_mid();
      test_widths();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/iface_rsp_responder.md
# iface_rsp_responder

Responder end of the team's parameterized request/response interface: accepts DW-bit requests tagged with an ID, buffers them in a DEPTH-entry FIFO, processes one at a time, and returns a tagged response with an overflow flag. It sits on the target side of an interface port whose width is set only by the DW parameter. It is the counterpart to existing initiator-side blocks and is used to exercise parameterized interface ports end to end.

## Interface
Parameters:
- DW, 8, data width of request and response payload; legal range 1..32.
- DEPTH, 4, request FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_data  in  DW  request payload.
- req_id  in  4  request tag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts the response.
- rsp_data  out  DW  response payload.
- rsp_id  out  4  tag copied from the request.
- rsp_err  out  1  payload arithmetic overflowed.
- occupancy  out  $clog2(DEPTH)+1  number of FIFO entries in use.
- err_count  out  8  saturating count of responses delivered with rsp_err=1.

## Operation
- A request is accepted on a clk edge with req_valid=1 and req_ready=1. {req_id, req_data} is pushed into the FIFO.
- req_ready = (occupancy != DEPTH). It is a combinational function of registered state only. A pop in the same cycle does not raise req_ready while the FIFO is full.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head and go to PROC. Otherwise stay in IDLE.
  - PROC: compute sum = {1'b0, data} + DW at DW+1 bits. Register rsp_data = sum[DW-1:0], rsp_err = sum[DW], and rsp_id = the popped tag. Go to RESP.
  - RESP: hold rsp_valid=1 with rsp_data, rsp_id and rsp_err stable until rsp_ready=1. On that handshake edge, go to IDLE.
- rsp_valid=1 exactly in RESP. Response outputs must not change while rsp_valid=1 and rsp_ready=0.
- Push and pop on the same edge are both honoured, so occupancy is unchanged. Pointers wrap modulo DEPTH.
- err_count increments on each response handshake with rsp_err=1 and saturates at 255.
- Responses are delivered in request order. Exactly one response is produced per accepted request.
- Values of req_data and req_id are ignored when req_valid=0.

## Timing
- Reset (rst_n=0 at a clk edge) forces the following values on that edge, regardless of in-flight traffic:
  - FSM to IDLE.
  - FIFO pointers and occupancy to 0.
  - rsp_valid, rsp_data, rsp_id and rsp_err to 0.
  - err_count to 0.
  - req_ready is therefore 1 after reset.
- A request pending at reset is discarded. No response is ever produced for it.
- Latency: request accepted at edge E0, popped at E1 (IDLE→PROC), rsp_valid=1 after E2. The minimum is 2 cycles from the acceptance edge to rsp_valid.
- If rsp_ready=1 when rsp_valid rises, the handshake completes at E3. The earliest next rsp_valid for a queued request is then after E5. Peak throughput is one response per 3 cycles.
- Backpressure: the FIFO keeps accepting while RESP stalls, until occupancy==DEPTH.
- Overflow boundary: DW=8 with req_data=247 gives rsp_data=255, rsp_err=0. req_data=248 gives rsp_data=0, rsp_err=1.

## Test plan
- Reset then a single request (DW=8, data=0x10, id=3) with rsp_ready=1 → rsp_valid after 2 cycles, rsp_data=0x18, rsp_id=3, rsp_err=0. After the handshake, occupancy=0.
- Overflow: send data 247 then 248, then 255 → rsp_data 255/0/7, rsp_err 0/1/1, err_count=2.
- Fill with rsp_ready=0: push 6 requests (ids 0..5) back-to-back with DEPTH=4.
  - req_ready drops once occupancy=4; 5 requests are accepted, 4 in the FIFO and 1 in RESP.
  - rsp_data stays stable while stalled.
  - Release rsp_ready → ids 0..4 return in order, then id 5 after it is accepted.
- Simultaneous push/pop: keep occupancy at 2 and push on the IDLE→PROC edge → occupancy stays 2. Pointers wrap past DEPTH-1 with no loss or duplication over 20 requests.
- Reset mid-operation: assert rst_n=0 for one edge while in RESP with 3 queued entries → all outputs are 0, occupancy=0, req_ready=1, and no stale responses appear afterwards.
- Width sweep with DW=1 and DW=32 (DW=1: data 0 → 1 with err 0, data 1 → 0 with err 1; DW=32: 0xFFFFFFE0 → 0x00000000 with err 1) → results are correct with no width warnings under lint.
